// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs op descriptors into 32-bit words and streams
// them to consecutive instruction-memory word addresses over a valid/ready port.
module instr_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_LUI   = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_BLT   = 4'd3;
  localparam logic [3:0] OP_JAL   = 4'd4;
  localparam logic [3:0] OP_JALR  = 4'd5;
  localparam logic [3:0] OP_LW    = 4'd6;
  localparam logic [3:0] OP_SW    = 4'd7;
  localparam logic [3:0] OP_ECALL = 4'd8;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              is_ecall;
  logic              accept;
  logic              imm_i_ok, imm_b_ok, imm_j_ok, imm_u_ok;

  // Immediate must be representable by the target format's sign-extended field.
  assign imm_i_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign imm_b_ok = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  assign imm_j_ok = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
  assign imm_u_ok = !(|in_imm[11:0]);

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    is_ecall = 1'b0;
    case (in_op)
      OP_LUI: begin
        enc_ok   = imm_u_ok;
        enc_word = {in_imm[31:12], in_rd, 7'b0110111};
      end
      OP_ADDI: begin
        enc_ok   = imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
      end
      OP_ADD: begin
        enc_word = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      end
      OP_BLT: begin
        enc_ok   = imm_b_ok;
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b100,
                    in_imm[4:1], in_imm[11], 7'b1100011};
      end
      OP_JAL: begin
        enc_ok   = imm_j_ok;
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                    in_rd, 7'b1101111};
      end
      OP_JALR: begin
        enc_ok   = imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      end
      OP_LW: begin
        enc_ok   = imm_i_ok;
        enc_word = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
      end
      OP_SW: begin
        enc_ok   = imm_i_ok;
        enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      end
      OP_ECALL: begin
        is_ecall = 1'b1;
        enc_word = 32'h0000_0073;
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign in_ready = (state == S_RUN) && (!mem_valid || mem_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_RUN) || mem_valid;
  assign done     = (state == S_DONE) && !mem_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the later mem_valid <= 1 overrides the earlier clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      instr_count <= '0;
    end else begin
      if (mem_valid && mem_ready) mem_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RUN;
            ptr         <= BASE_ADDR;
            err         <= 1'b0;
            ovf         <= 1'b0;
            instr_count <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (!enc_ok) begin
              err <= 1'b1;
            end else begin
              mem_valid   <= 1'b1;
              mem_addr    <= ptr;
              mem_wdata   <= enc_word;
              ptr         <= ptr + 1'b1;
              instr_count <= instr_count + 1'b1;
              if (&ptr) ovf <= 1'b1;
              if (is_ecall) state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 10-bit-address instance for encoding,
// stalls, rejects and reset, plus a 2-bit-address instance for pointer wrap.
module tb_instr_encoder;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, mem_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_valid, busy, done, err, ovf;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] instr_count;

  logic        s_in_ready, s_mem_valid, s_busy, s_done, s_err, s_ovf;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_instr_count;

  int checks = 0;
  int failures = 0;
  int hs_count = 0;
  int exp_ptr;
  int hs_base;

  vec_t burst[12];
  vec_t rejects[7];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .instr_count(instr_count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_valid(s_mem_valid), .mem_ready(mem_ready), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .busy(s_busy), .done(s_done), .err(s_err), .ovf(s_ovf),
    .instr_count(s_instr_count)
  );

  always @(posedge clk) if (mem_valid && mem_ready) hs_count <= hs_count + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_op    = v.op;
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
  endtask

  task automatic drive_fields(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    vec_t v;
    v = '{name: "", op: op, rd: rd, rs1: rs1, rs2: rs2, imm: imm, word: 32'h0};
    drive(v);
  endtask

  initial begin
    burst[0]  = '{name: "add",       op: 4'd2, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, imm: 32'h0,        word: 32'h002081B3};
    burst[1]  = '{name: "lui",       op: 4'd0, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, imm: 32'h12345000, word: 32'h123452B7};
    burst[2]  = '{name: "blt_p8",    op: 4'd3, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'd8,        word: 32'h0020C463};
    burst[3]  = '{name: "sw_12",     op: 4'd7, rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'd12,       word: 32'h0020A623};
    burst[4]  = '{name: "jal_16",    op: 4'd4, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'd16,       word: 32'h010000EF};
    burst[5]  = '{name: "jalr",      op: 4'd5, rd: 5'd1, rs1: 5'd5, rs2: 5'd0, imm: 32'h0,        word: 32'h000280E7};
    burst[6]  = '{name: "lw_m4",     op: 4'd6, rd: 5'd6, rs1: 5'd2, rs2: 5'd0, imm: 32'hFFFFFFFC, word: 32'hFFC12303};
    burst[7]  = '{name: "blt_m8",    op: 4'd3, rd: 5'd0, rs1: 5'd3, rs2: 5'd4, imm: 32'hFFFFFFF8, word: 32'hFE41CCE3};
    burst[8]  = '{name: "addi_2047", op: 4'd1, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'd2047,     word: 32'h7FF00093};
    burst[9]  = '{name: "jal_max",   op: 4'd4, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'h000FFFFE, word: 32'h7FFFF06F};
    burst[10] = '{name: "sw_m1",     op: 4'd7, rd: 5'd0, rs1: 5'd6, rs2: 5'd5, imm: 32'hFFFFFFFF, word: 32'hFE532FA3};
    burst[11] = '{name: "lui_neg",   op: 4'd0, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'hFFFFF000, word: 32'hFFFFF0B7};

    rejects[0] = '{name: "rej_addi_2048", op: 4'd1,  rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'd2048,     word: 32'h0};
    rejects[1] = '{name: "rej_op12",      op: 4'd12, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'h0,        word: 32'h0};
    rejects[2] = '{name: "rej_blt_odd",   op: 4'd3,  rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'd3,        word: 32'h0};
    rejects[3] = '{name: "rej_lui_low",   op: 4'd0,  rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'h00001001, word: 32'h0};
    rejects[4] = '{name: "rej_jal_range", op: 4'd4,  rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'h00100000, word: 32'h0};
    rejects[5] = '{name: "rej_sw_range",  op: 4'd7,  rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'hFFFFF7FF, word: 32'h0};
    rejects[6] = '{name: "rej_blt_range", op: 4'd3,  rd: 5'd0, rs1: 5'd1, rs2: 5'd2, imm: 32'h00001000, word: 32'h0};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ovf", ovf, 0);
    check("rst_count", instr_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    // Start and first ADDI x1,x0,5
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; mem_ready = 1'b1;
    check("run_busy", busy, 1);
    drive_fields(4'd1, 5'd1, 5'd0, 5'd0, 32'd5);
    #1 check("first_in_ready", in_ready, 1);
    @(negedge clk);
    check("first_valid", mem_valid, 1);
    check("first_addr", mem_addr, 0);
    check("first_word", mem_wdata, 32'h00500093);
    check("first_count", instr_count, 1);
    exp_ptr = 1;

    // Back-to-back burst, one word per cycle
    for (int i = 0; i < 12; i++) begin
      drive(burst[i]);
      #1 check({burst[i].name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      check({burst[i].name, "_valid"}, mem_valid, 1);
      check({burst[i].name, "_addr"}, mem_addr, exp_ptr);
      check({burst[i].name, "_word"}, mem_wdata, burst[i].word);
      exp_ptr++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("burst_drained", mem_valid, 0);
    check("burst_count", instr_count, exp_ptr);
    check("burst_err", err, 0);

    // Stall: mem_ready low for 3 cycles with a descriptor waiting
    mem_ready = 1'b0;
    hs_base = hs_count;
    drive_fields(4'd1, 5'd7, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    check("stall_a_addr", mem_addr, exp_ptr);
    check("stall_a_word", mem_wdata, 32'h00100393);
    drive_fields(4'd2, 5'd8, 5'd7, 5'd7, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #1 check("stall_in_ready", in_ready, 0);
      @(negedge clk);
      check("stall_hold_valid", mem_valid, 1);
      check("stall_hold_addr", mem_addr, exp_ptr);
      check("stall_hold_word", mem_wdata, 32'h00100393);
    end
    mem_ready = 1'b1;
    #1 check("stall_release_ready", in_ready, 1);
    @(negedge clk);
    check("stall_b_addr", mem_addr, exp_ptr + 1);
    check("stall_b_word", mem_wdata, 32'h00738433);
    in_valid = 1'b0;
    @(negedge clk);
    check("stall_handshakes", hs_count - hs_base, 2);
    exp_ptr += 2;

    // Rejected descriptors: accepted, err set, nothing written
    hs_base = hs_count;
    for (int i = 0; i < 7; i++) begin
      drive(rejects[i]);
      #1 check({rejects[i].name, "_in_ready"}, in_ready, 1);
      @(negedge clk);
      check({rejects[i].name, "_no_write"}, mem_valid, 0);
      check({rejects[i].name, "_err"}, err, 1);
    end
    check("rej_count", instr_count, exp_ptr);
    check("rej_handshakes", hs_count - hs_base, 0);
    drive_fields(4'd1, 5'd9, 5'd0, 5'd0, 32'hFFFFF800);
    @(negedge clk);
    check("after_rej_addr", mem_addr, exp_ptr);
    check("after_rej_word", mem_wdata, 32'h80000493);
    check("after_rej_err_sticky", err, 1);
    in_valid = 1'b0;

    // Wrap on the 2-bit instance: 5 ADDI then ECALL
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) drive_fields(4'd1, 5'd1, 5'd1, 5'd0, 32'd1);
      else       drive_fields(4'd8, 5'd0, 5'd0, 5'd0, 32'h0);
      #1 check("wrap_in_ready", s_in_ready, 1);
      @(negedge clk);
      check("wrap_addr", s_mem_addr, k % 4);
      check("wrap_word", s_mem_wdata, (k < 5) ? 32'h00108093 : 32'h00000073);
    end
    check("wrap_ovf", s_ovf, 1);
    check("wrap_count", s_instr_count, 6);
    check("ecall_done_pending", s_done, 0);
    check("ecall_busy_pending", s_busy, 1);
    check("ecall_in_ready", s_in_ready, 0);
    drive_fields(4'd1, 5'd2, 5'd0, 5'd0, 32'd7);
    @(negedge clk);
    check("ecall_done", s_done, 1);
    check("ecall_busy", s_busy, 0);
    check("ecall_refuse", s_in_ready, 0);
    @(negedge clk);
    check("ecall_no_write", s_mem_valid, 0);
    check("ecall_count_held", s_instr_count, 6);
    check("big_no_ovf", ovf, 0);
    in_valid = 1'b0;

    // Async reset while a write is pending, then restart
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; mem_ready = 1'b0;
    drive_fields(4'd1, 5'd1, 5'd0, 5'd0, 32'd5);
    @(negedge clk);
    check("pre_rst_valid", mem_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", mem_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_addr", mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; mem_ready = 1'b1;
    drive_fields(4'd2, 5'd3, 5'd1, 5'd2, 32'h0);
    #1 check("start_idle_in_ready", in_ready, 0);
    @(negedge clk); start = 1'b0;
    check("start_only_no_write", mem_valid, 0);
    #1 check("restart_in_ready", in_ready, 1);
    @(negedge clk);
    check("restart_addr", mem_addr, 0);
    check("restart_word", mem_wdata, 32'h002081B3);
    check("restart_count", instr_count, 1);
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder that packs operation descriptors (op class, register indices, 32-bit immediate) into 32-bit instruction words. It writes them to consecutive instruction-memory word addresses through a valid/ready write port. Its op set and bit layouts are exactly what the core's instruction decoder accepts: LUI, ADDI, ADD, BLT, JAL, JALR, LW, SW, ECALL. It loads test programs and self-generated code into instruction memory ahead of core execution.

## Interface
- ADDR_W, 10, word-address width of instruction memory
- BASE_ADDR, 0, first word address written after start
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse, begins a program load
- in_valid  input  1  descriptor valid
- in_ready  output  1  descriptor accepted when in_valid && in_ready
- in_op  input  4  0 LUI, 1 ADDI, 2 ADD, 3 BLT, 4 JAL, 5 JALR, 6 LW, 7 SW, 8 ECALL, 9-15 illegal
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_imm  input  32  signed byte immediate (LUI: full upper value, low 12 bits zero)
- mem_valid  output  1  write request
- mem_ready  input  1  memory accepts write when mem_valid && mem_ready
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  32  encoded instruction
- busy  output  1  state RUN or output register occupied
- done  output  1  state DONE and mem_valid low
- err  output  1  sticky, any rejected descriptor since start
- ovf  output  1  sticky, address wrapped past 2^ADDR_W-1
- instr_count  output  ADDR_W+1  words written since start

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE. All outputs 0 at reset; mem_addr and mem_wdata 0.
- start in IDLE or DONE: -> RUN. Write pointer loads BASE_ADDR. instr_count, err and ovf clear. start in RUN is ignored.
- in_ready = (state == RUN) && (!mem_valid || mem_ready).
- Encodings (funct7 = 0 throughout):
  - LUI 0110111, U-type.
  - ADDI 0010011, f3 000.
  - ADD 0110011, f3 000.
  - BLT 1100011, f3 100, B-type.
  - JAL 1101111, J-type.
  - JALR 1100111, f3 000.
  - LW 0000011, f3 010.
  - SW 0100011, f3 010, S-type.
  - ECALL 0x00000073.
- Unused fields are 0: rd for BLT/SW, rs2 for I/U/J types, everything for ECALL.
- Range checks; a violation rejects the descriptor:
  - I/S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal, in_imm[0]=0.
  - J: in_imm[31:20] all equal, in_imm[0]=0.
  - U: in_imm[11:0]=0.
- Rejected descriptor (illegal op or range violation): accepted (handshake completes), err set, no write issued, pointer and count unchanged.
- Valid descriptor: output register loads {pointer, word}, mem_valid=1. Pointer increments modulo 2^ADDR_W; instr_count increments.
- Pointer wrap from all-ones to 0 sets ovf. Writing continues.
- Accepted ECALL (valid): state -> DONE after loading its word. No further descriptors accepted.
- Output register holds stable while mem_valid && !mem_ready.
- Async reset mid-load: immediate return to IDLE, pending write dropped, mem_valid low.

## Timing
- Latency: descriptor accepted at edge N -> mem_valid/mem_wdata valid after edge N, so visible in cycle N+1.
- Throughput 1 word/cycle with mem_ready held high.
- Simultaneous handshake: mem_ready and a new accept in the same cycle replace the output register; no bubble.
- done asserts the cycle after the ECALL word's mem handshake.
- busy deasserts the same cycle done asserts.
- start and a same-cycle in_valid in IDLE: only start acts. in_ready is 0 that cycle.

## Test plan
- Reset, start, ADDI x1,x0,5 -> mem_addr 0, mem_wdata 0x00500093, instr_count 1.
- Burst, mem_ready=1:
  - ADD x3,x1,x2 -> 0x002081B3.
  - LUI x5,0x12345000 -> 0x123452B7.
  - BLT x1,x2,+8 -> 0x0020C463.
  - SW x2,12(x1) -> 0x0020A623.
  - JAL x1,+16 -> 0x010000EF.
  - Result: consecutive addresses, one word per cycle.
- mem_ready held 0 for 3 cycles mid-burst -> mem_addr/mem_wdata stable, in_ready 0, no word lost or duplicated.
- ADDI imm 2048, then op 12, then BLT imm 3 -> err=1, no writes, pointer unchanged. Next valid op writes the same address.
- ADDR_W=2: 5 ADDI then ECALL -> addresses 0,1,2,3,0,1, ovf=1. ECALL word 0x00000073 at 1. done 1 after handshake; descriptors refused afterwards.
- rst_n low while mem_valid=1 -> mem_valid 0 immediately, IDLE. Restart with start writes from BASE_ADDR.
